mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control sequencer for the CPU datapath: the instruction fetch unit, the 32-entry register file and the ALU. It accepts one instruction at a time from the fetch unit and steps it through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the ALU operation, register-file write enable, PC update and data-memory request/acknowledge handshake. It replaces the externally driven `wr_en` and `alu_op_i` of the CPU top level.

## Interface

No parameters.

- `clk` in 1 — system clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `instr_i` in 32 — instruction from the fetch unit.
- `instr_valid_i` in 1 — `instr_i` is valid.
- `instr_ready_o` out 1 — controller accepts an instruction this cycle.
- `zero_i` in 1 — ALU zero flag.
- `mem_ack_i` in 1 — data-memory access complete.
- `alu_op_o` out 4 — ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `alu_src_b_o` out 1 — ALU operand B source: 0 = rs2 data, 1 = sign-extended `IR[15:0]`.
- `reg_wr_en_o` out 1 — register-file write enable.
- `reg_dst_o` out 1 — write register select: 0 = rt `IR[20:16]`, 1 = rd `IR[15:11]`.
- `mem_to_reg_o` out 1 — write-back source: 1 = memory read data, 0 = ALU result.
- `mem_req_o` out 1 — data-memory request.
- `mem_we_o` out 1 — data-memory write; qualified by `mem_req_o`.
- `pc_en_o` out 1 — PC update strobe.
- `pc_src_o` out 2 — next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- `ir_o` out 32 — latched instruction register.
- `illegal_o` out 1 — one-cycle pulse on an undecodable instruction.
- `state_o` out 3 — current state.
- `retired_o` out 32 — count of retired instructions.

## Operation

- States and `state_o` encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Encodings 6 and 7 return to IDLE on the next clock.
- IDLE → FETCH unconditionally.
- FETCH:
  - `instr_ready_o`=1.
  - On `instr_valid_i`=1, latch `instr_i` into IR and go to DECODE; otherwise stay.
- DECODE: classify the instruction using opcode `IR[31:26]` and funct `IR[5:0]`.
  - R-type (opcode 0x00), with funct → ALU op: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
  - I-type and jump opcodes: ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
  - Any other opcode, or an unlisted funct with opcode 0x00, is illegal: pulse `illegal_o`, pulse `pc_en_o` with `pc_src_o`=00, count the instruction as retired, go to FETCH.
  - Otherwise go to EXEC.
- EXEC, by instruction:
  - R-type: `alu_op_o` from funct, `alu_src_b_o`=0; go to WB.
  - ADDI, LW, SW: `alu_op_o`=ADD, `alu_src_b_o`=1. ADDI goes to WB; LW and SW go to MEM.
  - BEQ: `alu_op_o`=SUB, `alu_src_b_o`=0. Pulse `pc_en_o` with `pc_src_o`=01 if `zero_i` is 1, else 00. Retire; go to FETCH.
  - J: pulse `pc_en_o` with `pc_src_o`=10. Retire; go to FETCH.
- MEM:
  - `mem_req_o`=1, `mem_we_o`=1 for SW and 0 for LW; `alu_op_o`=ADD and `alu_src_b_o`=1 held.
  - Stay until `mem_ack_i`=1.
  - On ack, SW pulses `pc_en_o` (`pc_src_o`=00), retires and goes to FETCH; LW goes to WB.
- WB:
  - `reg_wr_en_o`=1 for one cycle. `reg_dst_o`=1 for R-type, 0 for ADDI and LW. `mem_to_reg_o`=1 for LW only.
  - For R-type and ADDI, `alu_op_o` and `alu_src_b_o` are held at their EXEC values.
  - Pulse `pc_en_o` (`pc_src_o`=00), retire, go to FETCH.
- Output decode:
  - All control outputs are a decode of state and IR only.
  - The single exception is `pc_src_o[0]` in EXEC for BEQ, which follows `zero_i` combinationally.
  - Any output not listed for a state is 0.
- `retired_o`: increments by 1 on each retire event and wraps from 0xFFFFFFFF to 0.

## Timing

- Reset (asynchronous):
  - State returns to IDLE; IR and `retired_o` clear to 0.
  - Every output is 0, including `instr_ready_o`, `mem_req_o` and `reg_wr_en_o`.
  - Reset mid-operation aborts the instruction: no write, no PC update, no retire.
- First `instr_ready_o`=1 occurs in the second cycle after `rst_n` rises (IDLE, then FETCH).
- Cycles from FETCH acceptance back to FETCH, with zero memory wait:
  - R-type and ADDI: 4.
  - SW: 4.
  - LW: 5.
  - BEQ and J: 3.
  - Illegal: 2.
  - Each cycle of waiting for `mem_ack_i` adds one cycle.
- Handshake rules:
  - `mem_req_o` stays asserted until the cycle in which `mem_ack_i`=1 is sampled, then deasserts on the next edge.
  - `mem_ack_i` outside MEM is ignored.
  - `instr_valid_i` outside FETCH is ignored; IR never changes outside FETCH.
- `pc_en_o` is asserted for exactly one cycle per instruction, simultaneous with the retire increment.

## Test plan

- **Reset and first fetch:** hold `rst_n`=0 for 3 cycles with `instr_valid_i`=1 → all outputs 0; after release, `state_o` reads 0 then 1, and `instr_ready_o`=1 on the second cycle.
- **ADD** `0x012A4020` (add $8,$9,$10):
  - DECODE one cycle after acceptance.
  - EXEC shows `alu_op_o`=0010, `alu_src_b_o`=0.
  - WB shows `reg_wr_en_o`=1, `reg_dst_o`=1, `mem_to_reg_o`=0.
  - `retired_o`=1; back in FETCH 4 cycles after acceptance.
- **LW** `0x8D280004` with `mem_ack_i` delayed 3 cycles → `mem_req_o`=1 and `mem_we_o`=0 for 4 cycles; then WB with `reg_dst_o`=0, `mem_to_reg_o`=1; total 8 cycles.
- **BEQ** `0x11090002`:
  - `zero_i`=1 → EXEC `alu_op_o`=0110, `pc_en_o`=1, `pc_src_o`=01.
  - Repeat with `zero_i`=0 → `pc_src_o`=00.
  - No `reg_wr_en_o` in either case.
- **Illegal opcode** `0xFC000000` → `illegal_o` pulses once in DECODE with `pc_en_o`=1, `pc_src_o`=00; `retired_o` increments; back in FETCH after 2 cycles.
- **Reset during MEM** (SW, no ack) → `mem_req_o` drops asynchronously; `retired_o` and IR read 0; no `pc_en_o` pulse; restart as in the first scenario.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the CPU datapath.
// Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives
// the ALU, register-file, PC and data-memory handshake controls.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        zero_i,
    input  logic        mem_ack_i,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_b_o,
    output logic        reg_wr_en_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        pc_en_o,
    output logic [1:0]  pc_src_o,
    output logic [31:0] ir_o,
    output logic        illegal_o,
    output logic [2:0]  state_o,
    output logic [31:0] retired_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5
    } state_e;

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    state_e      state_q, state_d;
    logic [31:0] ir_q;
    logic [31:0] retired_q;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_legal;
    logic [3:0] r_alu_op;
    logic       retire;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // Instruction classification from the latched IR
    always_comb begin
        r_alu_op = AluAdd;
        is_r     = 1'b0;
        if (opcode == OpRType) begin
            is_r = 1'b1;
            case (funct)
                6'h20:   r_alu_op = AluAdd;
                6'h22:   r_alu_op = AluSub;
                6'h24:   r_alu_op = AluAnd;
                6'h25:   r_alu_op = AluOr;
                6'h27:   r_alu_op = AluNor;
                6'h2A:   r_alu_op = AluSlt;
                default: is_r = 1'b0;
            endcase
        end
    end

    assign is_addi  = (opcode == OpAddi);
    assign is_lw    = (opcode == OpLw);
    assign is_sw    = (opcode == OpSw);
    assign is_beq   = (opcode == OpBeq);
    assign is_j     = (opcode == OpJ);
    assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

    // State register, instruction register and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch && instr_valid_i) begin
                ir_q <= instr_i;
            end
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // Next-state and control-output decode
    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        alu_op_o      = 4'b0000;
        alu_src_b_o   = 1'b0;
        reg_wr_en_o   = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        retire        = 1'b0;
        pc_src_o      = 2'b00;
        illegal_o     = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_legal) begin
                    state_d = StExec;
                end else begin
                    illegal_o = 1'b1;
                    retire    = 1'b1;
                    state_d   = StFetch;
                end
            end
            StExec: begin
                if (is_r) begin
                    alu_op_o = r_alu_op;
                    state_d  = StWb;
                end else if (is_addi || is_lw || is_sw) begin
                    alu_op_o    = AluAdd;
                    alu_src_b_o = 1'b1;
                    state_d     = is_addi ? StWb : StMem;
                end else if (is_beq) begin
                    alu_op_o = AluSub;
                    retire   = 1'b1;
                    // Branch decision is the one output that follows an input directly
                    pc_src_o = {1'b0, zero_i};
                    state_d  = StFetch;
                end else begin
                    retire   = 1'b1;
                    pc_src_o = 2'b10;
                    state_d  = StFetch;
                end
            end
            StMem: begin
                mem_req_o   = 1'b1;
                mem_we_o    = is_sw;
                alu_op_o    = AluAdd;
                alu_src_b_o = 1'b1;
                if (mem_ack_i) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_wr_en_o  = 1'b1;
                reg_dst_o    = is_r;
                mem_to_reg_o = is_lw;
                if (is_r) begin
                    alu_op_o = r_alu_op;
                end else if (is_addi) begin
                    alu_op_o    = AluAdd;
                    alu_src_b_o = 1'b1;
                end
                retire  = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc_en_o   = retire;
    assign ir_o      = ir_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule
